b_ctrl: RTL and testbench

Sequencing controller for the 8-bit calculator. It consumes the synchronised key events from the hex keypad, operator keypad, equal and clear paths, plus ALU status. It drives ALU load/start strobes, entry-register clears and display-mode selection, and replaces the ad-hoc `valid`/`equal` wiring between keypad, ALU and display blocks. It sits between the input blocks (sync, hex, op) and the datapath blocks (alu, dis).

---
 rtl/b_ctrl_pkg.sv | 29 ++
 rtl/b_ctrl_timer.sv | 35 +++
 rtl/b_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_b_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/b_ctrl_pkg.sv
// Shared types and constants for the calculator sequencing controller.
package b_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_OPA    = 3'd1,
        ST_OPER   = 3'd2,
        ST_OPB    = 3'd3,
        ST_EXEC   = 3'd4,
        ST_RESULT = 3'd5,
        ST_ERROR  = 3'd6
    } state_t;

    localparam logic [3:0] OP_NONE = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_MUL  = 4'd3;
    localparam logic [3:0] OP_DIV  = 4'd4;

    localparam logic [1:0] DIS_ENTRY  = 2'd0;
    localparam logic [1:0] DIS_RESULT = 2'd1;
    localparam logic [1:0] DIS_ERROR  = 2'd2;
    localparam logic [1:0] DIS_BLANK  = 2'd3;

    function automatic logic is_valid_op(input logic [3:0] code);
        return (code >= OP_ADD) && (code <= OP_DIV);
    endfunction

endpackage

// File: rtl/b_ctrl_timer.sv
// Saturating up-counter with sync clear and enable; flags when the last count is reached.
module b_ctrl_timer #(
    parameter int unsigned LIMIT = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int unsigned   W    = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [W-1:0]  LAST = W'(LIMIT - 1);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && (count_q != LAST)) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == LAST);

endmodule

// File: rtl/b_ctrl.sv
// Calculator sequencer: turns keypad/ALU events into ALU strobes, entry clears and display mode.
//   state  | meaning
//   IDLE   | blank display, waiting for the first digit
//   OPA    | entering operand A
//   OPER   | operator latched, showing A, waiting for B
//   OPB    | entering operand B
//   EXEC   | ALU running, watchdog active
//   RESULT | showing result, idle timer active
//   ERROR  | sticky until clear
module b_ctrl
    import b_ctrl_pkg::*;
#(
    parameter int unsigned ALU_TIMEOUT  = 16,
    parameter int unsigned IDLE_TIMEOUT = 2**20
) (
    input  logic       i_sys_clock,
    input  logic       i_sys_reset,
    input  logic       i_b_ctrl_clear,
    input  logic       i_b_ctrl_equal,
    input  logic       i_b_ctrl_hex_new,
    input  logic       i_b_ctrl_hex_overflow,
    input  logic       i_b_ctrl_op_valid,
    input  logic [3:0] i_b_ctrl_op_keycode,
    input  logic       i_b_ctrl_alu_done,
    input  logic       i_b_ctrl_alu_overflow,
    output logic       o_b_ctrl_alu_load,
    output logic       o_b_ctrl_alu_start,
    output logic       o_b_ctrl_alu_clr,
    output logic [3:0] o_b_ctrl_alu_op,
    output logic       o_b_ctrl_hex_clear,
    output logic [1:0] o_b_ctrl_dis_mode,
    output logic       o_b_ctrl_busy,
    output logic [2:0] o_b_ctrl_state
);

    state_t     state_q, state_d;
    logic [3:0] alu_op_q, alu_op_d;
    logic [3:0] next_op_q, next_op_d;
    logic       chain_q, chain_d;
    logic       load_q, load_d;
    logic       start_q, start_d;
    logic       aclr_q, aclr_d;
    logic       hclr_q, hclr_d;
    logic [1:0] dis_q, dis_d;
    logic       busy_q, busy_d;

    logic ev_clr, ev_done, ev_eq, ev_op, ev_hex, op_ok, key_evt;
    logic wd_exp, idle_exp;

    // Only the highest-priority event of the cycle is presented to the FSM.
    assign ev_clr  = i_b_ctrl_clear;
    assign ev_done = !ev_clr && i_b_ctrl_alu_done;
    assign ev_eq   = !ev_clr && !i_b_ctrl_alu_done && i_b_ctrl_equal;
    assign ev_op   = !ev_clr && !i_b_ctrl_alu_done && !i_b_ctrl_equal && i_b_ctrl_op_valid;
    assign ev_hex  = !ev_clr && !i_b_ctrl_alu_done && !i_b_ctrl_equal && !i_b_ctrl_op_valid
                     && i_b_ctrl_hex_new;
    assign op_ok   = ev_op && is_valid_op(i_b_ctrl_op_keycode);
    assign key_evt = i_b_ctrl_clear | i_b_ctrl_equal | i_b_ctrl_hex_new | i_b_ctrl_op_valid;

    always_comb begin
        state_d   = state_q;
        alu_op_d  = alu_op_q;
        next_op_d = next_op_q;
        chain_d   = chain_q;
        load_d    = 1'b0;
        start_d   = 1'b0;
        aclr_d    = 1'b0;
        hclr_d    = 1'b0;
        if (ev_clr) begin
            state_d  = ST_IDLE;
            hclr_d   = 1'b1;
            aclr_d   = 1'b1;
            alu_op_d = OP_NONE;
            chain_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ev_hex) state_d = ST_OPA;
                end
                ST_OPA: begin
                    if (i_b_ctrl_hex_overflow) begin
                        state_d = ST_ERROR;
                    end else if (op_ok) begin
                        load_d   = 1'b1;
                        hclr_d   = 1'b1;
                        alu_op_d = i_b_ctrl_op_keycode;
                        state_d  = ST_OPER;
                    end
                end
                ST_OPER: begin
                    if (op_ok) alu_op_d = i_b_ctrl_op_keycode;
                    else if (ev_hex) state_d = ST_OPB;
                end
                ST_OPB: begin
                    if (i_b_ctrl_hex_overflow) begin
                        state_d = ST_ERROR;
                    end else if (ev_eq) begin
                        start_d = 1'b1;
                        chain_d = 1'b0;
                        state_d = ST_EXEC;
                    end else if (op_ok) begin
                        start_d   = 1'b1;
                        chain_d   = 1'b1;
                        next_op_d = i_b_ctrl_op_keycode;
                        state_d   = ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (ev_done) begin
                        if (i_b_ctrl_alu_overflow) begin
                            state_d = ST_ERROR;
                        end else if (chain_q) begin
                            alu_op_d = next_op_q;
                            hclr_d   = 1'b1;
                            state_d  = ST_OPER;
                        end else begin
                            hclr_d  = 1'b1;
                            state_d = ST_RESULT;
                        end
                    end else if (wd_exp) begin
                        state_d = ST_ERROR;
                    end
                end
                ST_RESULT: begin
                    if (ev_hex) begin
                        state_d = ST_OPA;
                    end else if (op_ok) begin
                        alu_op_d = i_b_ctrl_op_keycode;
                        state_d  = ST_OPER;
                    end else if (!key_evt && idle_exp) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_ERROR;
            endcase
        end
    end

    always_comb begin
        dis_d = dis_q;
        case (state_d)
            ST_IDLE:   dis_d = DIS_BLANK;
            ST_OPA:    dis_d = DIS_ENTRY;
            ST_OPB:    dis_d = DIS_ENTRY;
            ST_OPER:   dis_d = DIS_RESULT;
            ST_RESULT: dis_d = DIS_RESULT;
            ST_ERROR:  dis_d = DIS_ERROR;
            default:   dis_d = dis_q;
        endcase
        busy_d = (state_d == ST_EXEC);
    end

    b_ctrl_timer #(.LIMIT(ALU_TIMEOUT)) u_wdog (
        .clk_i     (i_sys_clock),
        .rst_ni    (i_sys_reset),
        .clr_i     ((state_d == ST_EXEC) && (state_q != ST_EXEC)),
        .en_i      (state_q == ST_EXEC),
        .expired_o (wd_exp)
    );

    b_ctrl_timer #(.LIMIT(IDLE_TIMEOUT)) u_idle (
        .clk_i     (i_sys_clock),
        .rst_ni    (i_sys_reset),
        .clr_i     (((state_d == ST_RESULT) && (state_q != ST_RESULT)) || key_evt),
        .en_i      (state_q == ST_RESULT),
        .expired_o (idle_exp)
    );

    always_ff @(posedge i_sys_clock) begin
        if (!i_sys_reset) begin
            state_q   <= ST_IDLE;
            alu_op_q  <= OP_NONE;
            next_op_q <= OP_NONE;
            chain_q   <= 1'b0;
            load_q    <= 1'b0;
            start_q   <= 1'b0;
            aclr_q    <= 1'b0;
            hclr_q    <= 1'b0;
            dis_q     <= DIS_BLANK;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            alu_op_q  <= alu_op_d;
            next_op_q <= next_op_d;
            chain_q   <= chain_d;
            load_q    <= load_d;
            start_q   <= start_d;
            aclr_q    <= aclr_d;
            hclr_q    <= hclr_d;
            dis_q     <= dis_d;
            busy_q    <= busy_d;
        end
    end

    assign o_b_ctrl_alu_load  = load_q;
    assign o_b_ctrl_alu_start = start_q;
    assign o_b_ctrl_alu_clr   = aclr_q;
    assign o_b_ctrl_alu_op    = alu_op_q;
    assign o_b_ctrl_hex_clear = hclr_q;
    assign o_b_ctrl_dis_mode  = dis_q;
    assign o_b_ctrl_busy      = busy_q;
    assign o_b_ctrl_state     = state_q;

endmodule

// File: tb/tb_b_ctrl.sv
// Scoreboard bench for b_ctrl: per-cycle expected outputs queued with stimulus, drained after the edge.
module tb_b_ctrl;
    import b_ctrl_pkg::*;

    localparam int EV_NONE = 0;
    localparam int EV_CLR  = 1;
    localparam int EV_EQ   = 2;
    localparam int EV_HEX  = 4;
    localparam int EV_OP   = 8;
    localparam int EV_DONE = 16;

    localparam logic [3:0] S_NONE  = 4'b0000;
    localparam logic [3:0] S_LOAD  = 4'b1000;
    localparam logic [3:0] S_START = 4'b0100;
    localparam logic [3:0] S_ACLR  = 4'b0010;
    localparam logic [3:0] S_HCLR  = 4'b0001;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clear, equal, hex_new, hex_ovf, op_valid, alu_done, alu_ovf;
    logic [3:0] op_code;
    logic       alu_load, alu_start, alu_clr, hex_clear, busy;
    logic [3:0] alu_op;
    logic [1:0] dis_mode;
    logic [2:0] state;

    always #5 clk = ~clk;

    b_ctrl #(.ALU_TIMEOUT(16), .IDLE_TIMEOUT(8)) dut (
        .i_sys_clock           (clk),
        .i_sys_reset           (rst_n),
        .i_b_ctrl_clear        (clear),
        .i_b_ctrl_equal        (equal),
        .i_b_ctrl_hex_new      (hex_new),
        .i_b_ctrl_hex_overflow (hex_ovf),
        .i_b_ctrl_op_valid     (op_valid),
        .i_b_ctrl_op_keycode   (op_code),
        .i_b_ctrl_alu_done     (alu_done),
        .i_b_ctrl_alu_overflow (alu_ovf),
        .o_b_ctrl_alu_load     (alu_load),
        .o_b_ctrl_alu_start    (alu_start),
        .o_b_ctrl_alu_clr      (alu_clr),
        .o_b_ctrl_alu_op       (alu_op),
        .o_b_ctrl_hex_clear    (hex_clear),
        .o_b_ctrl_dis_mode     (dis_mode),
        .o_b_ctrl_busy         (busy),
        .o_b_ctrl_state        (state)
    );

    typedef struct {
        string      tag;
        int         sel;
        logic [7:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    function automatic logic [7:0] observe(input int sel);
        case (sel)
            0:       return {5'b0, state};
            1:       return {4'b0, alu_op};
            2:       return {6'b0, dis_mode};
            3:       return {7'b0, busy};
            default: return {4'b0, alu_load, alu_start, alu_clr, hex_clear};
        endcase
    endfunction

    task automatic expect_out(input string tag, input state_t st, input logic [3:0] op,
                              input logic [1:0] dm, input logic bz, input logic [3:0] stb);
        sb_q.push_back('{tag: {tag, ".state"},   sel: 0, val: {5'b0, st}});
        sb_q.push_back('{tag: {tag, ".alu_op"},  sel: 1, val: {4'b0, op}});
        sb_q.push_back('{tag: {tag, ".dis"},     sel: 2, val: {6'b0, dm}});
        sb_q.push_back('{tag: {tag, ".busy"},    sel: 3, val: {7'b0, bz}});
        sb_q.push_back('{tag: {tag, ".strobes"}, sel: 4, val: {4'b0, stb}});
    endtask

    task automatic tick(input int ev, input logic [3:0] code);
        exp_t e;
        clear    = (ev & EV_CLR)  != 0;
        equal    = (ev & EV_EQ)   != 0;
        hex_new  = (ev & EV_HEX)  != 0;
        op_valid = (ev & EV_OP)   != 0;
        alu_done = (ev & EV_DONE) != 0;
        op_code  = code;
        @(posedge clk);
        #1;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_val(e.tag, observe(e.sel), e.val);
        end
        clear    = 1'b0;
        equal    = 1'b0;
        hex_new  = 1'b0;
        op_valid = 1'b0;
        alu_done = 1'b0;
        op_code  = 4'd0;
    endtask

    // IDLE -> OPA -> OPER(op 1, load) -> OPB
    task automatic go_opb(input string tag, input logic [3:0] prev_op);
        expect_out({tag, ".opa"},  ST_OPA,  prev_op, DIS_ENTRY,  1'b0, S_NONE);
        tick(EV_HEX, 4'd0);
        expect_out({tag, ".oper"}, ST_OPER, 4'd1,    DIS_RESULT, 1'b0, S_LOAD | S_HCLR);
        tick(EV_OP, 4'd1);
        expect_out({tag, ".opb"},  ST_OPB,  4'd1,    DIS_ENTRY,  1'b0, S_NONE);
        tick(EV_HEX, 4'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation still running, expected completion");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; clear = 0; equal = 0; hex_new = 0; hex_ovf = 0;
        op_valid = 0; alu_done = 0; alu_ovf = 0; op_code = 4'd0;
        tick(EV_NONE, 4'd0);
        expect_out("reset", ST_IDLE, 4'd0, DIS_BLANK, 1'b0, S_NONE);
        tick(EV_NONE, 4'd0);
        rst_n = 1'b1;

        // basic A op B =
        expect_out("idle_eq", ST_IDLE, 4'd0, DIS_BLANK, 1'b0, S_NONE);
        tick(EV_EQ, 4'd0);
        expect_out("idle_op", ST_IDLE, 4'd0, DIS_BLANK, 1'b0, S_NONE);
        tick(EV_OP, 4'd1);
        go_opb("basic", 4'd0);
        expect_out("basic.start", ST_EXEC, 4'd1, DIS_ENTRY, 1'b1, S_START);
        tick(EV_EQ, 4'd0);
        for (int i = 0; i < 2; i++) begin
            expect_out("basic.wait", ST_EXEC, 4'd1, DIS_ENTRY, 1'b1, S_NONE);
            tick(EV_NONE, 4'd0);
        end
        expect_out("basic.done", ST_RESULT, 4'd1, DIS_RESULT, 1'b0, S_HCLR);
        tick(EV_DONE, 4'd0);
        expect_out("basic.hold", ST_RESULT, 4'd1, DIS_RESULT, 1'b0, S_NONE);
        tick(EV_NONE, 4'd0);

        // chaining: A op1 B op3 -> done -> OPER with op 3
        expect_out("chain.clr", ST_IDLE, 4'd0, DIS_BLANK, 1'b0, S_ACLR | S_HCLR);
        tick(EV_CLR, 4'd0);
        go_opb("chain", 4'd0);
        expect_out("chain.start", ST_EXEC, 4'd1, DIS_ENTRY, 1'b1, S_START);
        tick(EV_OP, 4'd3);
        expect_out("chain.wait", ST_EXEC, 4'd1, DIS_ENTRY, 1'b1, S_NONE);
        tick(EV_EQ, 4'd0);
        expect_out("chain.done", ST_OPER, 4'd3, DIS_RESULT, 1'b0, S_HCLR);
        tick(EV_DONE, 4'd0);
        expect_out("chain.opb", ST_OPB, 4'd3, DIS_ENTRY, 1'b0, S_NONE);
        tick(EV_HEX, 4'd0);
        expect_out("chain.start2", ST_EXEC, 4'd3, DIS_ENTRY, 1'b1, S_START);
        tick(EV_EQ, 4'd0);
        expect_out("chain.done2", ST_RESULT, 4'd3, DIS_RESULT, 1'b0, S_HCLR);
        tick(EV_DONE, 4'd0);
        expect_out("result.op", ST_OPER, 4'd2, DIS_RESULT, 1'b0, S_NONE);
        tick(EV_OP, 4'd2);
        expect_out("oper.replace", ST_OPER, 4'd4, DIS_RESULT, 1'b0, S_NONE);
        tick(EV_OP, 4'd4);

        // invalid op, hex overflow, error stickiness
        expect_out("err.clr", ST_IDLE, 4'd0, DIS_BLANK, 1'b0, S_ACLR | S_HCLR);
        tick(EV_CLR, 4'd0);
        expect_out("err.opa", ST_OPA, 4'd0, DIS_ENTRY, 1'b0, S_NONE);
        tick(EV_HEX, 4'd0);
        expect_out("err.op9", ST_OPA, 4'd0, DIS_ENTRY, 1'b0, S_NONE);
        tick(EV_OP, 4'd9);
        expect_out("err.oper", ST_OPER, 4'd1, DIS_RESULT, 1'b0, S_LOAD | S_HCLR);
        tick(EV_OP, 4'd1);
        expect_out("err.opb", ST_OPB, 4'd1, DIS_ENTRY, 1'b0, S_NONE);
        tick(EV_HEX, 4'd0);
        hex_ovf = 1'b1;
        expect_out("err.ovf", ST_ERROR, 4'd1, DIS_ERROR, 1'b0, S_NONE);
        tick(EV_NONE, 4'd0);
        hex_ovf = 1'b0;
        expect_out("err.eq", ST_ERROR, 4'd1, DIS_ERROR, 1'b0, S_NONE);
        tick(EV_EQ, 4'd0);
        expect_out("err.clear", ST_IDLE, 4'd0, DIS_BLANK, 1'b0, S_ACLR | S_HCLR);
        tick(EV_CLR, 4'd0);

        // watchdog: 16 EXEC cycles without done -> ERROR in the 17th
        go_opb("wd", 4'd0);
        expect_out("wd.start", ST_EXEC, 4'd1, DIS_ENTRY, 1'b1, S_START);
        tick(EV_EQ, 4'd0);
        for (int i = 0; i < 15; i++) begin
            expect_out("wd.exec", ST_EXEC, 4'd1, DIS_ENTRY, 1'b1, S_NONE);
            tick(EV_NONE, 4'd0);
        end
        expect_out("wd.fire", ST_ERROR, 4'd1, DIS_ERROR, 1'b0, S_NONE);
        tick(EV_NONE, 4'd0);
        expect_out("wd.late_done", ST_ERROR, 4'd1, DIS_ERROR, 1'b0, S_NONE);
        tick(EV_DONE, 4'd0);
        expect_out("wd.clear", ST_IDLE, 4'd0, DIS_BLANK, 1'b0, S_ACLR | S_HCLR);
        tick(EV_CLR, 4'd0);

        // idle timeout without keys: 8 RESULT cycles then IDLE
        go_opb("to", 4'd0);
        expect_out("to.start", ST_EXEC, 4'd1, DIS_ENTRY, 1'b1, S_START);
        tick(EV_EQ, 4'd0);
        expect_out("to.result", ST_RESULT, 4'd1, DIS_RESULT, 1'b0, S_HCLR);
        tick(EV_DONE, 4'd0);
        for (int i = 0; i < 7; i++) begin
            expect_out("to.wait", ST_RESULT, 4'd1, DIS_RESULT, 1'b0, S_NONE);
            tick(EV_NONE, 4'd0);
        end
        expect_out("to.idle", ST_IDLE, 4'd1, DIS_BLANK, 1'b0, S_NONE);
        tick(EV_NONE, 4'd0);
        expect_out("to.late_done", ST_IDLE, 4'd1, DIS_BLANK, 1'b0, S_NONE);
        tick(EV_DONE, 4'd0);

        // idle timeout restarted by a key press in RESULT
        go_opb("rs", 4'd1);
        expect_out("rs.start", ST_EXEC, 4'd1, DIS_ENTRY, 1'b1, S_START);
        tick(EV_EQ, 4'd0);
        expect_out("rs.result", ST_RESULT, 4'd1, DIS_RESULT, 1'b0, S_HCLR);
        tick(EV_DONE, 4'd0);
        for (int i = 0; i < 4; i++) begin
            expect_out("rs.pre", ST_RESULT, 4'd1, DIS_RESULT, 1'b0, S_NONE);
            tick(EV_NONE, 4'd0);
        end
        expect_out("rs.key", ST_RESULT, 4'd1, DIS_RESULT, 1'b0, S_NONE);
        tick(EV_EQ, 4'd0);
        for (int i = 0; i < 7; i++) begin
            expect_out("rs.post", ST_RESULT, 4'd1, DIS_RESULT, 1'b0, S_NONE);
            tick(EV_NONE, 4'd0);
        end
        expect_out("rs.idle", ST_IDLE, 4'd1, DIS_BLANK, 1'b0, S_NONE);
        tick(EV_NONE, 4'd0);

        // ALU overflow on a chained execution
        go_opb("ao", 4'd1);
        expect_out("ao.start", ST_EXEC, 4'd1, DIS_ENTRY, 1'b1, S_START);
        tick(EV_OP, 4'd2);
        alu_ovf = 1'b1;
        expect_out("ao.err", ST_ERROR, 4'd1, DIS_ERROR, 1'b0, S_NONE);
        tick(EV_DONE, 4'd0);
        alu_ovf = 1'b0;
        expect_out("ao.clear", ST_IDLE, 4'd0, DIS_BLANK, 1'b0, S_ACLR | S_HCLR);
        tick(EV_CLR, 4'd0);

        // clear and done together: clear wins
        go_opb("cd", 4'd0);
        expect_out("cd.start", ST_EXEC, 4'd1, DIS_ENTRY, 1'b1, S_START);
        tick(EV_EQ, 4'd0);
        expect_out("cd.both", ST_IDLE, 4'd0, DIS_BLANK, 1'b0, S_ACLR | S_HCLR);
        tick(EV_CLR | EV_DONE, 4'd0);

        // reset mid-EXEC
        go_opb("rx", 4'd0);
        expect_out("rx.start", ST_EXEC, 4'd1, DIS_ENTRY, 1'b1, S_START);
        tick(EV_EQ, 4'd0);
        rst_n = 1'b0;
        expect_out("rx.reset", ST_IDLE, 4'd0, DIS_BLANK, 1'b0, S_NONE);
        tick(EV_NONE, 4'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            expect_out("rx.after", ST_IDLE, 4'd0, DIS_BLANK, 1'b0, S_NONE);
            tick(EV_NONE, 4'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
